// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline sequencer.
// Stage-register vectors are indexed PC=0 .. MEM_WB=4.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_e;

  localparam int PC_R       = 0;
  localparam int IFID_R     = 1;
  localparam int IDEX_R     = 2;
  localparam int EXMEM_R    = 3;
  localparam int MEMWB_R    = 4;
  localparam int NSTAGE_REG = 5;

  typedef logic [NSTAGE_REG-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// Request-to-hold/bubble encoder: the deepest stalled stage holds
// itself and everything upstream, and bubbles the stage below it.
module stall_prio
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] req,
  output stage_vec_t stall,
  output stage_vec_t bubble
);

  always_comb begin
    stall  = '0;
    bubble = '0;
    priority case (1'b1)
      req[3]: begin
        stall  = 5'b01111;
        bubble = 5'b10000;
      end
      req[2]: begin
        stall  = 5'b00111;
        bubble = 5'b01000;
      end
      req[1]: begin
        stall  = 5'b00011;
        bubble = 5'b00100;
      end
      req[0]: begin
        stall  = 5'b00001;
        bubble = 5'b00010;
      end
      default: begin
        stall  = '0;
        bubble = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush vectors, PC redirect,
// exception drain and post-redirect IF_ID squash window.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int REDIR_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_if,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  stallreq_mem,
  input  logic                  br_taken_ex,
  input  logic [ADDR_WIDTH-1:0] br_target_ex,
  input  logic                  excp_mem,
  input  logic [ADDR_WIDTH-1:0] excp_entry,
  input  logic                  ertn_mem,
  input  logic [ADDR_WIDTH-1:0] era,
  input  logic                  mem_busy,
  output logic [4:0]            stall,
  output logic [4:0]            flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [1:0]            ctrl_state
);

  localparam logic [2:0] HOLD_INIT =
    (REDIR_HOLD > 0) ? 3'(REDIR_HOLD - 1) : 3'd0;
  localparam ctrl_state_e POST_REDIR =
    (REDIR_HOLD > 0) ? HOLD : RUN;

  ctrl_state_e           state;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] tgt_q;

  stage_vec_t            req_stall;
  stage_vec_t            req_bubble;
  stage_vec_t            st_v;
  stage_vec_t            fl_v;
  stage_vec_t            hold_fl;
  logic                  rv;
  logic                  go_drain;
  logic                  mem_ev;
  logic                  br_ok;
  logic [ADDR_WIDTH-1:0] mem_tgt;
  logic [ADDR_WIDTH-1:0] rpc;

  stall_prio u_prio (
    .req    ({stallreq_mem, stallreq_ex,
              stallreq_id, stallreq_if}),
    .stall  (req_stall),
    .bubble (req_bubble)
  );

  always_comb begin
    mem_ev   = excp_mem | ertn_mem;
    mem_tgt  = excp_mem ? excp_entry : era;
    br_ok    = br_taken_ex & ~stallreq_ex & ~stallreq_mem;
    hold_fl  = (state == HOLD) ? 5'b00010 : 5'b00000;
    st_v     = '0;
    fl_v     = '0;
    rv       = 1'b0;
    rpc      = '0;
    go_drain = 1'b0;
    if (state == DRAIN) begin
      if (mem_busy) begin
        st_v = 5'b01111;
        fl_v = 5'b10000;
      end else begin
        fl_v = 5'b11110;
        rv   = 1'b1;
        rpc  = tgt_q;
      end
    end else if (mem_ev && mem_busy) begin
      st_v     = 5'b01111;
      fl_v     = 5'b10000;
      go_drain = 1'b1;
    end else if (mem_ev) begin
      fl_v = 5'b11110;
      rv   = 1'b1;
      rpc  = mem_tgt;
    end else if (br_ok) begin
      fl_v = 5'b00110 | hold_fl | req_bubble;
      st_v = req_stall & ~fl_v & ~5'b00001;
      rv   = 1'b1;
      rpc  = br_target_ex;
    end else begin
      // a flushed register must never also be held
      fl_v = req_bubble | hold_fl;
      st_v = req_stall & ~fl_v;
    end
  end

  assign stall          = rst ? '0 : st_v;
  assign flush          = rst ? '0 : fl_v;
  assign redirect_valid = rst ? 1'b0 : rv;
  assign redirect_pc    = rst ? '0 : rpc;
  assign ctrl_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      tgt_q <= '0;
    end else if (go_drain) begin
      state <= DRAIN;
      tgt_q <= mem_tgt;
    end else if (rv) begin
      state <= POST_REDIR;
      cnt   <= HOLD_INIT;
    end else if (state == HOLD) begin
      if (cnt == 3'd0) state <= RUN;
      else             cnt   <= cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expectations queued per cycle,
// popped and compared at the falling edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stallreq_if = 0, stallreq_id = 0;
  logic          stallreq_ex = 0, stallreq_mem = 0;
  logic          br_taken_ex = 0;
  logic [AW-1:0] br_target_ex = '0;
  logic          excp_mem = 0;
  logic [AW-1:0] excp_entry = '0;
  logic          ertn_mem = 0;
  logic [AW-1:0] era = '0;
  logic          mem_busy = 0;
  logic [4:0]    stall, flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [1:0]    ctrl_state;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_WIDTH(AW), .REDIR_HOLD(1)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex),
    .excp_mem(excp_mem), .excp_entry(excp_entry),
    .ertn_mem(ertn_mem), .era(era), .mem_busy(mem_busy),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ctrl_state(ctrl_state)
  );

  typedef struct packed {
    logic [4:0]    s;
    logic [4:0]    f;
    logic          rv;
    logic [AW-1:0] pc;
    logic [1:0]    st;
  } obs_t;

  typedef struct packed {
    logic [3:0]    req;
    logic          br;
    logic [AW-1:0] bt;
    logic          ex;
    logic [AW-1:0] ee;
    logic          er;
    logic [AW-1:0] ra;
    logic          busy;
  } in_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  obs_t  got, want;
  string nm;

  localparam logic [AW-1:0] B1 = 32'h1C00_0100;
  localparam logic [AW-1:0] B2 = 32'h1C00_0240;
  localparam logic [AW-1:0] B3 = 32'h1C00_0380;
  localparam logic [AW-1:0] EE = 32'h1C00_8000;
  localparam logic [AW-1:0] RA = 32'h1C00_1234;

  function automatic obs_t mk_o(logic [4:0] s, logic [4:0] f,
      logic rv, logic [AW-1:0] pc, ctrl_state_e st);
    obs_t o;
    o.s = s; o.f = f; o.rv = rv; o.pc = pc; o.st = st;
    return o;
  endfunction

  function automatic in_t mk_i(logic [3:0] req, logic br,
      logic [AW-1:0] bt, logic ex, logic [AW-1:0] ee,
      logic er, logic [AW-1:0] ra, logic busy);
    in_t x;
    x.req = req; x.br = br; x.bt = bt; x.ex = ex;
    x.ee = ee; x.er = er; x.ra = ra; x.busy = busy;
    return x;
  endfunction

  task automatic drive(in_t x);
    stallreq_if  = x.req[0];
    stallreq_id  = x.req[1];
    stallreq_ex  = x.req[2];
    stallreq_mem = x.req[3];
    br_taken_ex  = x.br;
    br_target_ex = x.bt;
    excp_mem     = x.ex;
    excp_entry   = x.ee;
    ertn_mem     = x.er;
    era          = x.ra;
    mem_busy     = x.busy;
  endtask

  task automatic test_reset();
    stallreq_ex = 1'b1;
    br_taken_ex = 1'b1;
    #2;
    exp_q.push_back(mk_o(5'b0, 5'b0, 1'b0, '0, RUN));
    name_q.push_back("reset_held");
    got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
    want = exp_q.pop_front(); nm = name_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
    drive(mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(mk_o(5'b0, 5'b0, 1'b0, '0, RUN));
    name_q.push_back("reset_idle");
    @(negedge clk);
    got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
    want = exp_q.pop_front(); nm = name_q.pop_front();
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_prio();
    for (int r = 0; r < 16; r++) begin
      int k;
      logic [4:0] s, f;
      k = -1;
      for (int j = 0; j < 4; j++) if (r[j]) k = j;
      s = (k < 0) ? 5'b0 : 5'((1 << (k + 1)) - 1);
      f = (k < 0) ? 5'b0 : 5'(1 << (k + 1));
      drive(mk_i(4'(r), 0, '0, 0, '0, 0, '0, 0));
      exp_q.push_back(mk_o(s, f, 1'b0, '0, RUN));
      name_q.push_back($sformatf("stall_req%b", 4'(r)));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    in_t  si[5];
    obs_t so[5];
    si[0] = mk_i(4'b0, 1, B1, 0, '0, 0, '0, 0);
    so[0] = mk_o(5'b0, 5'b00110, 1, B1, RUN);
    si[1] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[1] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[2] = si[1];
    so[2] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    si[3] = mk_i(4'b0011, 0, '0, 0, '0, 0, '0, 0);
    so[3] = mk_o(5'b00011, 5'b00100, 0, '0, RUN);
    si[4] = mk_i(4'b1010, 0, '0, 0, '0, 0, '0, 0);
    so[4] = mk_o(5'b01111, 5'b10000, 0, '0, RUN);
    for (int i = 0; i < 5; i++) begin
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("branch[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_blocked();
    in_t  si[5];
    obs_t so[5];
    si[0] = mk_i(4'b1000, 1, B2, 0, '0, 0, '0, 0);
    so[0] = mk_o(5'b01111, 5'b10000, 0, '0, RUN);
    si[1] = si[0];
    so[1] = so[0];
    si[2] = mk_i(4'b0000, 1, B2, 0, '0, 0, '0, 0);
    so[2] = mk_o(5'b0, 5'b00110, 1, B2, RUN);
    si[3] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[3] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[4] = si[3];
    so[4] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    for (int i = 0; i < 5; i++) begin
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("br_blocked[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain();
    in_t  si[6];
    obs_t so[6];
    si[0] = mk_i(4'b0, 0, '0, 1, EE, 0, '0, 1);
    so[0] = mk_o(5'b01111, 5'b10000, 0, '0, RUN);
    si[1] = mk_i(4'b0001, 1, B3, 1, 32'hDEAD_0000, 1, RA, 1);
    so[1] = mk_o(5'b01111, 5'b10000, 0, '0, DRAIN);
    si[2] = si[1];
    so[2] = so[1];
    si[3] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[3] = mk_o(5'b0, 5'b11110, 1, EE, DRAIN);
    si[4] = si[3];
    so[4] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[5] = si[3];
    so[5] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    for (int i = 0; i < 6; i++) begin
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("drain[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    in_t  si[6];
    obs_t so[6];
    si[0] = mk_i(4'b0, 1, B1, 1, EE, 1, RA, 0);
    so[0] = mk_o(5'b0, 5'b11110, 1, EE, RUN);
    si[1] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[1] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[2] = si[1];
    so[2] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    si[3] = mk_i(4'b0, 1, B1, 0, EE, 1, RA, 0);
    so[3] = mk_o(5'b0, 5'b11110, 1, RA, RUN);
    si[4] = si[1];
    so[4] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[5] = si[1];
    so[5] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    for (int i = 0; i < 6; i++) begin
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("priority[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    in_t  si[8];
    obs_t so[8];
    si[0] = mk_i(4'b0, 1, B1, 0, '0, 0, '0, 0);
    so[0] = mk_o(5'b0, 5'b00110, 1, B1, RUN);
    si[1] = mk_i(4'b0, 1, B2, 0, '0, 0, '0, 0);
    so[1] = mk_o(5'b0, 5'b00110, 1, B2, HOLD);
    si[2] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[2] = mk_o(5'b0, 5'b00010, 0, '0, HOLD);
    si[3] = si[2];
    so[3] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    si[4] = mk_i(4'b0100, 1, B3, 0, '0, 0, '0, 0);
    so[4] = mk_o(5'b00111, 5'b01000, 0, '0, RUN);
    si[5] = mk_i(4'b0000, 1, B3, 0, '0, 0, '0, 0);
    so[5] = mk_o(5'b0, 5'b00110, 1, B3, RUN);
    si[6] = mk_i(4'b1000, 0, '0, 0, '0, 0, '0, 0);
    so[6] = mk_o(5'b01101, 5'b10010, 0, '0, HOLD);
    si[7] = si[2];
    so[7] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    for (int i = 0; i < 8; i++) begin
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("b2b[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_drain();
    in_t  si[4];
    obs_t so[4];
    si[0] = mk_i(4'b0, 0, '0, 1, EE, 0, '0, 1);
    so[0] = mk_o(5'b01111, 5'b10000, 0, '0, RUN);
    si[1] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 1);
    so[1] = mk_o(5'b01111, 5'b10000, 0, '0, DRAIN);
    si[2] = mk_i(4'b0, 0, '0, 0, '0, 0, '0, 0);
    so[2] = mk_o(5'b0, 5'b0, 0, '0, RUN);
    si[3] = si[2];
    so[3] = so[2];
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(mk_o(5'b0, 5'b0, 0, '0, RUN));
        name_q.push_back("rst_mid_drain");
        got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
        want = exp_q.pop_front(); nm = name_q.pop_front();
        n_chk++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", nm, got, want);
        end
        mem_busy = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
      end
      drive(si[i]);
      exp_q.push_back(so[i]);
      name_q.push_back($sformatf("rst_drain[%0d]", i));
      @(negedge clk);
      got = {stall, flush, redirect_valid, redirect_pc, ctrl_state};
      want = exp_q.pop_front(); nm = name_q.pop_front();
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_stall_prio();
    test_branch();
    test_branch_blocked();
    test_drain();
    test_priority();
    test_back_to_back();
    test_reset_drain();
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
